// File: rtl/tick_scheduler.sv
// Slow-clock run-control: programmable-period tick enable and slow_clk, with HALT/RUN/STEP modes.
// Optional bounded-run feature enabled by defining TICK_SCHED_BURST_EN.
module tick_scheduler #(
    parameter int               CNT_W          = 32,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(25_000_000)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_period,
    output logic             cfg_ready,
`ifdef TICK_SCHED_BURST_EN
    input  logic [15:0]      burst_len,
    output logic             burst_done,
`endif
    output logic             tick,
    output logic             slow_clk,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] tick_count
);

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0] pend_period_q, pend_period_d;
    logic             slow_clk_q, slow_clk_d;
    logic [CNT_W-1:0] tick_count_q, tick_count_d;

    logic             xfer;
    logic             entering_halt;
    logic [CNT_W-1:0] cfg_clamped;

`ifdef TICK_SCHED_BURST_EN
    logic [15:0]      burst_len_q, burst_len_d;
    logic [15:0]      burst_cnt_q, burst_cnt_d;
    logic             burst_done_q, burst_done_d;
    logic             burst_end;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        period_d      = period_q;
        pend_valid_d  = pend_valid_q;
        pend_period_d = pend_period_q;
        slow_clk_d    = slow_clk_q;
        tick_count_d  = tick_count_q;
`ifdef TICK_SCHED_BURST_EN
        burst_len_d   = burst_len_q;
        burst_cnt_d   = burst_cnt_q;
        burst_done_d  = 1'b0;
        burst_end     = 1'b0;
`endif

        tick        = (state_q != HALT) && (cnt_q == period_q - CNT_W'(1));
        cfg_ready   = (state_q == HALT) || !pend_valid_q;
        xfer        = cfg_valid && cfg_ready;
        cfg_clamped = (cfg_period == '0) ? CNT_W'(1) : cfg_period;

`ifdef TICK_SCHED_BURST_EN
        burst_end = (state_q == RUN) && tick && (burst_len_q != 16'd0)
                    && (burst_cnt_q == burst_len_q - 16'd1);
`endif

        // Command priority is stop > step > start; commands outside HALT other than stop are dropped.
        case (state_q)
            HALT: begin
                if (stop) begin
                    state_d = HALT;
                end else if (step) begin
                    state_d = STEP;
                end else if (start) begin
                    state_d = RUN;
`ifdef TICK_SCHED_BURST_EN
                    burst_len_d = burst_len;
                    burst_cnt_d = 16'd0;
`endif
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = HALT;
`ifdef TICK_SCHED_BURST_EN
                end else if (burst_end) begin
                    state_d      = HALT;
                    burst_done_d = 1'b1;
`endif
                end
            end
            STEP: begin
                if (stop || tick) state_d = HALT;
            end
            default: state_d = HALT;
        endcase

        if (state_q != HALT) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

        if (tick) begin
            slow_clk_d   = ~slow_clk_q;
            tick_count_d = tick_count_q + CNT_W'(1);
`ifdef TICK_SCHED_BURST_EN
            burst_cnt_d  = burst_cnt_q + 16'd1;
`endif
        end

        entering_halt = (state_q != HALT) && (state_d == HALT);
        if (entering_halt) cnt_d = '0;

        // A transfer on the edge that enters HALT would otherwise leave a stale pending entry.
        if (xfer) begin
            if (state_q == HALT || entering_halt) begin
                period_d = cfg_clamped;
            end else begin
                pend_period_d = cfg_clamped;
                pend_valid_d  = 1'b1;
            end
        end

        if (pend_valid_q && (tick || entering_halt)) begin
            period_d     = pend_period_q;
            pend_valid_d = 1'b0;
            cnt_d        = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= HALT;
            cnt_q         <= '0;
            period_q      <= DEFAULT_PERIOD;
            pend_valid_q  <= 1'b0;
            pend_period_q <= '0;
            slow_clk_q    <= 1'b0;
            tick_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            pend_valid_q  <= pend_valid_d;
            pend_period_q <= pend_period_d;
            slow_clk_q    <= slow_clk_d;
            tick_count_q  <= tick_count_d;
        end
    end

`ifdef TICK_SCHED_BURST_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            burst_len_q  <= 16'd0;
            burst_cnt_q  <= 16'd0;
            burst_done_q <= 1'b0;
        end else begin
            burst_len_q  <= burst_len_d;
            burst_cnt_q  <= burst_cnt_d;
            burst_done_q <= burst_done_d;
        end
    end

    assign burst_done = burst_done_q;
`endif

    assign state      = state_q;
    assign slow_clk   = slow_clk_q;
    assign tick_count = tick_count_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: expected ticks are queued at stimulus time and
// matched by a monitor against the cycle, tick_count and slow_clk seen on each tick.
module tb_tick_scheduler;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             start, stop, step;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_period;
    logic             cfg_ready;
    logic             tick;
    logic             slow_clk;
    logic [1:0]       state;
    logic [CNT_W-1:0] tick_count;
`ifdef TICK_SCHED_BURST_EN
    logic [15:0]      burst_len;
    logic             burst_done;
`endif

    tick_scheduler #(.CNT_W(CNT_W), .DEFAULT_PERIOD(32'd6)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .cfg_valid  (cfg_valid),
        .cfg_period (cfg_period),
        .cfg_ready  (cfg_ready),
`ifdef TICK_SCHED_BURST_EN
        .burst_len  (burst_len),
        .burst_done (burst_done),
`endif
        .tick       (tick),
        .slow_clk   (slow_clk),
        .state      (state),
        .tick_count (tick_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [31:0] tc;
        logic        slow;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdl_tc = 0;
    logic        mdl_slow = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int at);
        exp_t e;
        e.at = at; e.tc = mdl_tc; e.slow = mdl_slow;
        q.push_back(e);
        mdl_tc++;
        mdl_slow = ~mdl_slow;
    endtask

    task automatic pulse(input logic a_start, input logic a_stop, input logic a_step);
        start = a_start; stop = a_stop; step = a_step;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; step = 1'b0;
    endtask

    task automatic set_period(input logic [31:0] p);
        cfg_valid = 1'b1; cfg_period = p;
        chk("cfg_ready_halt", {31'd0, cfg_ready}, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every tick must match the head of the expected queue.
    always @(negedge clk) begin
        if (tick) begin
            n_vec++;
            if (q.size() == 0 || q[0].at != cyc) begin
                n_err++;
                $display("FAIL tick_at: tick at cycle %0d, expected cycle %0d", cyc,
                         (q.size() == 0) ? -1 : q[0].at);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("tick_count_at_tick", tick_count, e.tc);
                chk("slow_clk_at_tick", {31'd0, slow_clk}, {31'd0, e.slow});
            end
        end else if (q.size() > 0 && q[0].at < cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL missed_tick: no tick seen, expected at cycle %0d", q[0].at);
            void'(q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d expected < 10000", cyc);
        $fatal(1, "timeout");
    end

    int c;
    initial begin
        n_rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
        cfg_valid = 1'b0; cfg_period = '0;
`ifdef TICK_SCHED_BURST_EN
        burst_len = 16'd0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_tick", {31'd0, tick}, 0);
        chk("rst_state", {30'd0, state}, 0);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 1);
        chk("rst_tick_count", tick_count, 0);
        chk("rst_slow_clk", {31'd0, slow_clk}, 0);
        n_rst = 1'b1;
        @(negedge clk);

        // Free run, P=4
        set_period(4);
        c = cyc;
        push(c + 4); push(c + 8); push(c + 12);
        pulse(1, 0, 0);
        chk("run_state", {30'd0, state}, 1);
        wait_cyc(c + 13);
        chk("run_tick_count", tick_count, 3);
        chk("run_slow_clk", {31'd0, slow_clk}, 1);
        pulse(0, 1, 0);
        chk("stop_state", {30'd0, state}, 0);

        // Single step, P=3
        set_period(3);
        c = cyc;
        push(c + 3);
        pulse(0, 0, 1);
        chk("step_state", {30'd0, state}, 2);
        wait_cyc(c + 3);
        chk("step_state_tick", {30'd0, state}, 2);
        @(negedge clk);
        chk("step_done_state", {30'd0, state}, 0);
        chk("step_tick_count", tick_count, 4);
        repeat (6) @(negedge clk);

        // Period change while running, P=10 -> 2; stop lands on a tick cycle
        set_period(10);
        c = cyc;
        push(c + 10); push(c + 12); push(c + 14); push(c + 16);
        pulse(1, 0, 0);
        wait_cyc(c + 3);
        cfg_valid = 1'b1; cfg_period = 2;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("cfg_ready_pending", {31'd0, cfg_ready}, 0);
        wait_cyc(c + 11);
        chk("cfg_ready_applied", {31'd0, cfg_ready}, 1);
        wait_cyc(c + 16);
        pulse(0, 1, 0);
        chk("stop_on_tick_state", {30'd0, state}, 0);
        chk("stop_on_tick_count", tick_count, 8);

        // Zero period clamps to 1; simultaneous commands from HALT stay in HALT
        set_period(0);
        pulse(1, 1, 1);
        chk("all_cmds_state", {30'd0, state}, 0);
        repeat (3) @(negedge clk);
        c = cyc;
        push(c + 1); push(c + 2); push(c + 3); push(c + 4);
        pulse(1, 0, 0);
        wait_cyc(c + 4);
        pulse(0, 1, 0);
        chk("p1_state", {30'd0, state}, 0);
        chk("p1_tick_count", tick_count, 12);

        // Reset mid-run with a pending period
        set_period(5);
        c = cyc;
        pulse(1, 0, 0);
        wait_cyc(c + 2);
        cfg_valid = 1'b1; cfg_period = 7;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("pend_cfg_ready", {31'd0, cfg_ready}, 0);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_tick", {31'd0, tick}, 0);
        chk("mid_rst_state", {30'd0, state}, 0);
        chk("mid_rst_tick_count", tick_count, 0);
        chk("mid_rst_slow_clk", {31'd0, slow_clk}, 0);
        chk("mid_rst_cfg_ready", {31'd0, cfg_ready}, 1);
        mdl_tc = 0; mdl_slow = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Default period (6) restored after reset
        c = cyc;
        push(c + 6); push(c + 12);
        pulse(1, 0, 0);
        wait_cyc(c + 12);
        pulse(0, 1, 0);
        chk("default_tick_count", tick_count, 2);

`ifdef TICK_SCHED_BURST_EN
        // Burst of three ticks at P=2
        set_period(2);
        burst_len = 16'd3;
        c = cyc;
        push(c + 2); push(c + 4); push(c + 6);
        pulse(1, 0, 0);
        burst_len = 16'd0;
        wait_cyc(c + 6);
        chk("burst_done_early", {31'd0, burst_done}, 0);
        @(negedge clk);
        chk("burst_end_state", {30'd0, state}, 0);
        chk("burst_done_pulse", {31'd0, burst_done}, 1);
        @(negedge clk);
        chk("burst_done_clear", {31'd0, burst_done}, 0);
        chk("burst_tick_count", tick_count, 5);
`endif

        repeat (8) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL queue_empty: got %0d pending ticks expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Run-control and timing scheduler for the slow-clock domain of the lab CPU. It produces a single-cycle `tick` clock-enable and a 50%-duty `slow_clk` from `clk` at a programmable period. It sequences them through halt, free-run and single-step modes, and accepts runtime period changes through a valid/ready handshake. The block sits between the board button/switch debouncers and every consumer that advances on the slow clock.

## Interface
Parameters:
- `CNT_W`, 32: width of the period register, the internal counter and `tick_count`.
- `DEFAULT_PERIOD`, 25_000_000: period in `clk` cycles loaded at reset.

Ports:
- `clk`, in, 1: system clock.
- `n_rst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: pulse; enter RUN.
- `stop`, in, 1: pulse; return to HALT.
- `step`, in, 1: pulse; emit exactly one tick, then HALT.
- `cfg_valid`, in, 1: new period offered.
- `cfg_period`, in, CNT_W: offered period in `clk` cycles.
- `cfg_ready`, out, 1: period can be accepted this cycle.
- `tick`, out, 1: one-cycle enable, once per period.
- `slow_clk`, out, 1: toggles at the end of every tick cycle.
- `state`, out, 2: HALT=00, RUN=01, STEP=10.
- `tick_count`, out, CNT_W: total ticks since reset; wraps.

## Operation
- Registers: `state`, `cnt`, `period`, `pend_valid`, `pend_period`, `slow_clk`, `tick_count`.
- Reset values: state HALT, `cnt` 0, `period` DEFAULT_PERIOD, pend_valid 0, `slow_clk` 0, `tick_count` 0. Consequently `tick`=0 and `cfg_ready`=1.
- `tick` = (state != HALT) && (cnt == period-1). It is decoded from registers only and has no input-to-output path.
- In RUN/STEP, `cnt` increments each cycle. On a tick cycle `cnt` returns to 0, `slow_clk` toggles and `tick_count` increments.
- State transitions (command priority stop > step > start):
  - HALT + start goes to RUN.
  - HALT + step goes to STEP.
  - RUN + stop goes to HALT.
  - STEP goes to HALT at the end of its tick cycle.
  - STEP + stop goes to HALT with no tick.
  - step or start while in RUN/STEP is ignored. start during STEP is not queued.
- Entering HALT clears `cnt` to 0. `slow_clk` holds its value.
- `cfg_ready` = (state == HALT) || !pend_valid. A transfer occurs when `cfg_valid && cfg_ready`.
- `cfg_period` == 0 is clamped to 1.
- A transfer in HALT writes `period` directly at that edge.
- A transfer in RUN/STEP writes `pend_period` and sets `pend_valid`. The pending value is applied at the edge ending the next tick cycle, where `cnt` is set to 0 and `pend_valid` cleared. It is also applied at the edge that enters HALT, whichever comes first.
- A transfer coinciding with the tick cycle that applies the pending value is impossible, because `cfg_ready` is 0 while pending.
- `tick_count` wraps from 2^CNT_W-1 to 0 silently.

## Timing
- Command to state: one edge. `state` changes at the first edge where the pulse is sampled high.
- First tick: with period P, entering RUN/STEP at edge E0 puts the first tick in the cycle after edge E0+(P-1). Ticks then repeat every P cycles.
- P=1: `tick` is high every cycle in RUN and `slow_clk` toggles every cycle.
- `slow_clk` period is 2P `clk` cycles. Its edges align with the edges ending tick cycles.
- stop during a tick cycle: that tick counts (the `slow_clk` toggle and `tick_count` increment happen), and the block is in HALT after that edge.
- Reset mid-operation: all registers return to reset values asynchronously. `tick` is low during reset. Any pending period is discarded.

## Configuration
- Macro `TICK_SCHED_BURST_EN`.
- Defined: adds ports `burst_len` (in, 16) and `burst_done` (out, 1, reset 0).
  - `burst_len` is sampled when `start` is accepted.
  - If non-zero, RUN exits to HALT at the edge ending the `burst_len`-th tick, and `burst_done` pulses for one cycle after that edge.
  - stop pre-empts the burst with no `burst_done`.
  - `burst_len`=0 means continuous run.
- Undefined: those ports are absent and RUN is continuous until stop.

## Test plan
- Reset, then set P=4 in HALT and pulse start: first tick 4 cycles after the RUN edge, ticks every 4 cycles, `slow_clk` period 8, `tick_count` 3 after 12 cycles in RUN.
- In HALT with P=3, pulse step: exactly one tick 3 cycles later, state back to 00 at the next edge, `tick_count` +1.
- In RUN with P=10, offer period 2 mid-period: `cfg_ready` drops to 0, the current period completes at 10 cycles, subsequent ticks come every 2 cycles, and `cfg_ready` returns to 1.
- Load `cfg_period`=0: `period` reads 1 and `tick` is high every RUN cycle. stop, step and start asserted together from HALT: state stays HALT.
- Assert reset mid-RUN with a pending period: all outputs return to reset values immediately. After release, the period is DEFAULT_PERIOD.
- With `TICK_SCHED_BURST_EN`, P=2 and `burst_len`=3: three ticks, HALT after the third tick, one `burst_done` pulse.
